// File: rtl/regfile_dump_if.sv
// Debug-dump bundle: start request, register-file read port, indexed output
// stream and the core stall/status signals.
interface regfile_dump_if;
  logic        start;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        busy;
  logic        freeze;
  logic        done;

  modport master (
    input  start, rf_data, out_ready,
    output rf_addr, out_valid, out_data, out_index, busy, freeze, done
  );

  modport slave (
    output start, rf_data, out_ready,
    input  rf_addr, out_valid, out_data, out_index, busy, freeze, done
  );
endinterface

// File: rtl/regfile_dump.sv
// Walks register indices FIRST..LAST through the combinational read port and
// streams each value tagged with its index, stalling the core while busy.
module regfile_dump #(
  parameter int unsigned FIRST = 0,
  parameter int unsigned LAST  = 31
) (
  input  logic           clk,
  input  logic           reset,
  regfile_dump_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST);
  localparam logic [4:0] LAST_IDX  = 5'(LAST);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_index_q, out_index_d;
  logic        done_q, done_d;
  logic        hs;

  assign hs = out_valid_q & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d   = FIRST_IDX;
          state_d = READ;
        end
      end
      READ: begin
        // Single sample of the read port; contents are held by freeze.
        out_data_d  = bus.rf_data;
        out_index_d = idx_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (hs) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = READ;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: all control and output state registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_index_q <= 5'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      done_q      <= done_d;
    end
  end

  assign bus.rf_addr   = idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.freeze    = (state_q != IDLE);
endmodule
